// File: rtl/fd_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : fd_pipe_stage
// Brief    : Fetch/decode pipeline register with a two-entry skid buffer,
//            registered in_ready, synchronous flush and NOP bubble output.
//            Optional stall counter enabled by defining FD_PIPE_STALL_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module fd_pipe_stage #(
    parameter int          PC_WIDTH  = 12,
    parameter int          IR_WIDTH  = 32,
    parameter logic [31:0] NOP_INSN  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic [IR_WIDTH-1:0] in_ir,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [IR_WIDTH-1:0] out_ir
`ifdef FD_PIPE_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

    // NOP_INSN is zero-extended first so any IR_WIDTH can slice it safely
    localparam logic [IR_WIDTH+31:0] c_nop_ext = {{IR_WIDTH{1'b0}}, NOP_INSN};
    localparam logic [IR_WIDTH-1:0]  c_nop     = c_nop_ext[IR_WIDTH-1:0];

    logic                r_main_valid;
    logic [PC_WIDTH-1:0] r_main_pc;
    logic [IR_WIDTH-1:0] r_main_ir;
    logic                r_skid_valid;
    logic [PC_WIDTH-1:0] r_skid_pc;
    logic [IR_WIDTH-1:0] r_skid_ir;

    logic w_accept;
    logic w_issue;

    assign in_ready  = !r_skid_valid;
    assign w_accept  = in_valid & !r_skid_valid;
    assign w_issue   = r_main_valid & out_ready;

    assign out_valid = r_main_valid;
    assign out_pc    = r_main_valid ? r_main_pc : '0;
    assign out_ir    = r_main_valid ? r_main_ir : c_nop;

    // Occupancy is encoded directly by the two valid bits:
    // EMPTY = 00, ONE = main only, FULL = both. Skid-only never occurs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_main_valid <= 1'b0;
            r_main_pc    <= '0;
            r_main_ir    <= c_nop;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_ir    <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid) begin
            if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_pc    <= in_pc;
                r_main_ir    <= in_ir;
            end
        end else if (!r_skid_valid) begin
            if (w_accept && w_issue) begin
                r_main_pc <= in_pc;
                r_main_ir <= in_ir;
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_pc    <= in_pc;
                r_skid_ir    <= in_ir;
            end else if (w_issue) begin
                r_main_valid <= 1'b0;
            end
        end else if (w_issue) begin
            r_main_pc    <= r_skid_pc;
            r_main_ir    <= r_skid_ir;
            r_skid_valid <= 1'b0;
        end
    end

`ifdef FD_PIPE_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    // Flush deliberately leaves the count alone; only clr clears it
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    // CNT_WIDTH only sizes the stall counter; referenced here to keep it live
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fd_pipe_stage.sv
`default_nettype none
// Testbench for fd_pipe_stage: directed scenarios plus randomized traffic,
// scoreboarded against a queue-based occupancy model.
module tb_fd_pipe_stage;

    localparam int          PW  = 12;
    localparam int          IW  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          CW  = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_pc = '0;
    logic [IW-1:0] in_ir = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_pc;
    logic [IW-1:0] out_ir;
`ifdef FD_PIPE_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    fd_pipe_stage #(
        .PC_WIDTH (PW),
        .IR_WIDTH (IW),
        .NOP_INSN (NOP),
        .CNT_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_ir    (in_ir),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_ir   (out_ir)
`ifdef FD_PIPE_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected output order, and model of how many entries the stage holds
    logic [PW+IW-1:0] sb_q[$];
    int               occ = 0;
    int               exp_stall = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs();
        chk("in_ready", {63'd0, in_ready}, 64'd1);
        chk("out_valid", {63'd0, out_valid}, 64'd0);
        chk("out_pc_bubble", {52'd0, out_pc}, 64'd0);
        chk("out_ir_bubble", {32'd0, out_ir}, {32'd0, NOP});
    endtask

    // Called at posedge+1: check state-level outputs, drive one cycle, predict.
    task automatic cycle(input logic iv, input logic [PW-1:0] pc, input logic [IW-1:0] ir,
                         input logic ordy, input logic fl);
        bit acc, iss;
        chk("in_ready", {63'd0, in_ready}, {63'd0, (occ < 2)});
        chk("out_valid", {63'd0, out_valid}, {63'd0, (occ > 0)});
        if (occ == 0) begin
            chk("out_pc_bubble", {52'd0, out_pc}, 64'd0);
            chk("out_ir_bubble", {32'd0, out_ir}, {32'd0, NOP});
        end
`ifdef FD_PIPE_STALL_CNT_EN
        chk("stall_cnt", {60'd0, stall_cnt}, 64'(exp_stall));
`endif
        in_valid  = iv;
        in_pc     = pc;
        in_ir     = ir;
        out_ready = ordy;
        flush     = fl;
        acc = iv && (occ < 2) && !fl;
        iss = (occ > 0) && ordy && !fl;
        if (acc) sb_q.push_back({pc, ir});
        if ((occ > 0) && !ordy && exp_stall < (1 << CW) - 1) exp_stall++;
        if (fl) occ = 0;
        else occ = occ - int'(iss) + int'(acc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, ordy, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a handshake
    initial begin
        logic [PW+IW-1:0] e;
        forever begin
            @(negedge clk);
            if (clr) begin
                if (out_valid && out_ready && !flush) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got pc=%h ir=%h expected none", out_pc, out_ir);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_entry", {20'd0, out_pc, out_ir}, {20'd0, e});
                    end
                end
                if (flush) sb_q.delete();
            end
        end
    end

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;

        // Streaming at full rate
        for (int i = 0; i < 10; i++) cycle(1'b1, PW'(i), 32'hA000_0000 + i, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Back-pressure fills the skid, then drains in order
        cycle(1'b1, 12'h100, 32'hB000_0100, 1'b1, 1'b0);
        cycle(1'b1, 12'h101, 32'hB000_0101, 1'b0, 1'b0);
        cycle(1'b1, 12'h102, 32'hB000_0102, 1'b0, 1'b0);
        cycle(1'b1, 12'h102, 32'hB000_0102, 1'b0, 1'b0);
        cycle(1'b1, 12'h102, 32'hB000_0102, 1'b1, 1'b0);
        cycle(1'b1, 12'h102, 32'hB000_0102, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Flush while FULL with a new entry on the input
        cycle(1'b1, 12'h1F0, 32'hC000_01F0, 1'b0, 1'b0);
        cycle(1'b1, 12'h1F1, 32'hC000_01F1, 1'b0, 1'b0);
        cycle(1'b1, 12'h200, 32'hC000_0200, 1'b1, 1'b1);
        cycle(1'b1, 12'h204, 32'hC000_0204, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Simultaneous accept and issue in ONE
        cycle(1'b1, 12'h300, 32'hD000_0300, 1'b1, 1'b0);
        cycle(1'b1, 12'h301, 32'hD000_0301, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Asynchronous reset in the middle of a FULL cycle
        cycle(1'b1, 12'h500, 32'hE000_0500, 1'b0, 1'b0);
        cycle(1'b1, 12'h501, 32'hE000_0501, 1'b0, 1'b0);
        #2;
        clr = 1'b0;
        #1;
        check_idle_outputs();
`ifdef FD_PIPE_STALL_CNT_EN
        chk("stall_cnt_reset", {60'd0, stall_cnt}, 64'd0);
`endif
        sb_q.delete();
        occ       = 0;
        exp_stall = 0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;

        // Long stall saturates the counter; flush must not clear it
        cycle(1'b1, 12'h400, 32'hF000_0400, 1'b0, 1'b0);
        idle(20, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 4) != 0, PW'($urandom), $urandom,
                  ($urandom % 3) != 0, ($urandom % 40) == 0);
        end
        idle(4, 1'b1);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
